// File: rtl/reset_sequencer.sv
// Staged per-domain reset release with software (quiesced) and watchdog in-run reset requests.
// All outputs registered; stage k drops HOLD_CYCLES + k*GAP_CYCLES edges after reset, no backpressure.
module reset_sequencer #(
  parameter int STAGES          = 3,
  parameter int HOLD_CYCLES     = 4,
  parameter int GAP_CYCLES      = 8,
  parameter int QUIESCE_TIMEOUT = 16,
  parameter int CNT_W           = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sw_req,
  input  logic              wdt_req,
  input  logic              quiesce_ack,
  output logic              quiesce_req,
  output logic [STAGES-1:0] rst_stage,
  output logic              ready,
  output logic [1:0]        cause
);

  localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_QUIESCE = 2'd3;

  localparam logic [1:0] CAUSE_POR     = 2'b00;
  localparam logic [1:0] CAUSE_SW      = 2'b01;
  localparam logic [1:0] CAUSE_WDT     = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  QTO_LAST  = CNT_W'(QUIESCE_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(STAGES - 1);
  localparam logic [STAGES-1:0] STAGE0    = STAGES'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_HOLD;
      cnt         <= '0;
      idx         <= '0;
      rst_stage   <= '1;
      ready       <= 1'b0;
      quiesce_req <= 1'b0;
      cause       <= CAUSE_POR;
    end else if (wdt_req) begin
      // Watchdog outranks everything and restarts the whole sequence from any state.
      state       <= ST_HOLD;
      cnt         <= '0;
      idx         <= '0;
      rst_stage   <= '1;
      ready       <= 1'b0;
      quiesce_req <= 1'b0;
      cause       <= CAUSE_WDT;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            rst_stage <= rst_stage & ~STAGE0;
            cnt       <= '0;
            idx       <= IDX_W'(1);
            if (STAGES == 1) begin
              state <= ST_RUN;
              ready <= 1'b1;
            end else begin
              state <= ST_RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (cnt == GAP_LAST) begin
            rst_stage <= rst_stage & ~(STAGE0 << idx);
            cnt       <= '0;
            if (idx == IDX_LAST) begin
              state <= ST_RUN;
              ready <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RUN: begin
          // Stage resets stay released while the datapath drains.
          if (sw_req) begin
            state       <= ST_QUIESCE;
            quiesce_req <= 1'b1;
            ready       <= 1'b0;
            cnt         <= '0;
          end
        end

        ST_QUIESCE: begin
          if (quiesce_ack || cnt == QTO_LAST) begin
            state       <= ST_HOLD;
            cnt         <= '0;
            idx         <= '0;
            rst_stage   <= '1;
            quiesce_req <= 1'b0;
            cause       <= quiesce_ack ? CAUSE_SW : CAUSE_TIMEOUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state       <= ST_HOLD;
          cnt         <= '0;
          idx         <= '0;
          rst_stage   <= '1;
          ready       <= 1'b0;
          quiesce_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: stimulus steps a time-based reference model and queues the expected outputs,
// a monitor compares them with the DUT after each rising edge.
module tb_reset_sequencer;

  localparam int S    = 3;
  localparam int HOLD = 4;
  localparam int GAP  = 8;
  localparam int QTO  = 16;

  localparam int M_SEQ = 0;
  localparam int M_RUN = 1;
  localparam int M_QSC = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sw_req = 1'b0;
  logic         wdt_req = 1'b0;
  logic         quiesce_ack = 1'b0;
  logic         quiesce_req;
  logic [S-1:0] rst_stage;
  logic         ready;
  logic [1:0]   cause;

  reset_sequencer #(
    .STAGES(S), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .QUIESCE_TIMEOUT(QTO), .CNT_W(5)
  ) dut (
    .clk(clk), .reset(reset), .sw_req(sw_req), .wdt_req(wdt_req), .quiesce_ack(quiesce_ack),
    .quiesce_req(quiesce_req), .rst_stage(rst_stage), .ready(ready), .cause(cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [S-1:0] rs;
    logic         rdy;
    logic         qr;
    logic [1:0]   cs;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  string phase = "init";
  int    vectors = 0;
  int    miscompares = 0;

  // Model: m_t = edges since the current release sequence began, m_q = edges since quiesce entry.
  int         m_mode = M_SEQ;
  int         m_t = 0;
  int         m_q = 0;
  logic [1:0] m_cause = 2'b00;

  task automatic model_step(input logic r, input logic s, input logic w, input logic a);
    if (r) begin
      m_mode = M_SEQ; m_t = 0; m_cause = 2'b00;
    end else if (w) begin
      m_mode = M_SEQ; m_t = 0; m_cause = 2'b10;
    end else if (m_mode == M_SEQ) begin
      m_t++;
      if (m_t >= HOLD + (S - 1) * GAP) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (s) begin
        m_mode = M_QSC; m_q = 0;
      end
    end else begin
      m_q++;
      if (a) begin
        m_mode = M_SEQ; m_t = 0; m_cause = 2'b01;
      end else if (m_q >= QTO) begin
        m_mode = M_SEQ; m_t = 0; m_cause = 2'b11;
      end
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o.rs = '0;
    for (int k = 0; k < S; k++)
      if (m_mode == M_SEQ && m_t < HOLD + k * GAP) o.rs[k] = 1'b1;
    o.rdy = (m_mode == M_RUN);
    o.qr  = (m_mode == M_QSC);
    o.cs  = m_cause;
    return o;
  endfunction

  task automatic apply(input logic r, input logic s, input logic w, input logic a);
    @(negedge clk);
    reset = r; sw_req = s; wdt_req = w; quiesce_ack = a;
    model_step(r, s, w, a);
    exp_q.push_back(model_out());
    tag_q.push_back(phase);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) apply(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    forever begin
      obs_t  e;
      obs_t  got;
      string t;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        got = {rst_stage, ready, quiesce_req, cause};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL %s @%0t: rst_stage=%b ready=%b quiesce_req=%b cause=%b, expected rst_stage=%b ready=%b quiesce_req=%b cause=%b",
                   t, $time, got.rs, got.rdy, got.qr, got.cs, e.rs, e.rdy, e.qr, e.cs);
        end
      end
    end
  end

  initial begin
    logic r, s, w, a;

    phase = "power_on";
    repeat (3) apply(1'b1, 1'b0, 1'b0, 1'b0);
    idle(24);

    phase = "sw_ack";
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    idle(24);

    phase = "quiesce_timeout";
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    idle(20);
    idle(24);

    phase = "sw_wdt_same_edge";
    apply(1'b0, 1'b1, 1'b1, 1'b0);
    idle(24);

    phase = "wdt_in_quiesce";
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    apply(1'b0, 1'b0, 1'b1, 1'b0);
    idle(24);

    phase = "ack_vs_timeout";
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    idle(QTO - 1);
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    idle(24);

    phase = "wdt_mid_release";
    repeat (2) apply(1'b1, 1'b0, 1'b0, 1'b0);
    idle(14);
    apply(1'b0, 1'b0, 1'b1, 1'b0);
    idle(24);

    phase = "reset_in_release";
    repeat (2) apply(1'b1, 1'b0, 1'b0, 1'b0);
    idle(8);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    idle(24);

    phase = "reset_in_quiesce";
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    phase = "sw_in_hold";
    repeat (2) apply(1'b0, 1'b1, 1'b0, 1'b0);
    idle(24);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      w = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 15) == 0);
      a = ($urandom_range(0, 5) == 0);
      apply(r, s, w, a);
    end

    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
